// File: rtl/parti_present_sbox_collect_chk_pkg.sv
// -----------------------------------------------------------------------------
// parti_present_pkg
// Shared constants, FSM state type and the PRESENT bit permutation used by the
// ParTi S-box output collector/checker.
//   SHARES   : Boolean shares per nibble (3 only)
//   NW       : nibble width in bits
//   NIBBLES  : nibbles per PRESENT state
//   STATE_W  : PRESENT state width
//   CNT_W    : width of the nibble counter
//   BASE_W   : width of a bit index into one state share
//   LAST_NIB : counter value of the final nibble of a state
// Optional build macro used by the top level: PARTI_ERR_CNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package parti_present_pkg;

  localparam int SHARES  = 3;
  localparam int NW      = 4;
  localparam int NIBBLES = 16;
  localparam int STATE_W = 64;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam int BASE_W  = $clog2(STATE_W);

  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    DONE    = 2'd2,
    ALARM   = 2'd3
  } collect_state_e;

  // PRESENT pLayer: bit j of nibble k lands on position NIBBLES*j + k.
  // Bit 63 maps onto itself.
  function automatic logic [STATE_W-1:0] present_player(input logic [STATE_W-1:0] din);
    logic [STATE_W-1:0] dout;
    dout = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      for (int j = 0; j < NW; j++) begin
        dout[NIBBLES*j + k] = din[NW*k + j];
      end
    end
    return dout;
  endfunction

endpackage

// File: rtl/parti_present_sbox_collect_chk_if.sv
// -----------------------------------------------------------------------------
// parti_present_sbox_collect_chk_if
// Handshake bundle between the serial S-box, the collector and the round
// datapath.
//   in_valid / in_ready : nibble beat handshake from the S-box
//   sbox_p / sbox_r     : primary / redundant shares, share s at [4s+3:4s]
//   out_valid/out_ready : state handshake towards the round datapath
//   state_sh            : pLayer'd shares, share s at [64s+63:64s]
// Modports: slave = collector side, master = S-box / datapath side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface parti_present_sbox_collect_chk_if
  import parti_present_pkg::*;
();

  logic                       in_valid;
  logic                       in_ready;
  logic [SHARES*NW-1:0]       sbox_p;
  logic [SHARES*NW-1:0]       sbox_r;
  logic                       out_valid;
  logic                       out_ready;
  logic [SHARES*STATE_W-1:0]  state_sh;

  modport slave (
    input  in_valid, sbox_p, sbox_r, out_ready,
    output in_ready, out_valid, state_sh
  );

  modport master (
    output in_valid, sbox_p, sbox_r, out_ready,
    input  in_ready, out_valid, state_sh
  );

endinterface

// File: rtl/parti_present_sbox_collect_chk_player.sv
// -----------------------------------------------------------------------------
// present_player_share
// Purely combinational pLayer for a single share. One instance exists per
// share so that shares never meet inside a common logic cone.
//   raw  : collected share, nibble k at [4k+3:4k]
//   perm : permuted share
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module present_player_share
  import parti_present_pkg::*;
(
  input  logic [STATE_W-1:0] raw,
  output logic [STATE_W-1:0] perm
);

  assign perm = present_player(raw);

endmodule

// File: rtl/parti_present_sbox_collect_chk.sv
// -----------------------------------------------------------------------------
// parti_present_sbox_collect_chk
// Collects 16 three-share S-box nibbles from the primary TI path into raw
// share registers, compares each beat against the redundant prediction path
// through registered share-wise differences, applies the pLayer per share and
// hands the shared state downstream. Any mismatch raises a sticky alarm and
// suppresses all outputs until reset.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : slave modport of parti_present_sbox_collect_chk_if
//   alarm   : sticky fault flag
//   err_cnt : saturating mismatch count (only with PARTI_ERR_CNT_EN)
// Build option: define PARTI_ERR_CNT_EN to add the err_cnt output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module parti_present_sbox_collect_chk
  import parti_present_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  parti_present_sbox_collect_chk_if.slave        bus,
  output logic                                   alarm
`ifdef PARTI_ERR_CNT_EN
  ,
  output logic [7:0]                             err_cnt
`endif
);

  collect_state_e                    state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q;
  logic [SHARES-1:0][STATE_W-1:0]    raw_q;
  logic [SHARES-1:0][NW-1:0]         diff_q;
  logic                              diff_valid_q;
  logic [SHARES-1:0][STATE_W-1:0]    player_w;
  logic [SHARES-1:0][STATE_W-1:0]    state_sh_q;
  logic                              alarm_q;
  logic                              live_q;

  logic                              in_ready_w;
  logic                              accept;
  logic [NW-1:0]                     diff_x;
  logic                              fault;
  logic [BASE_W-1:0]                 nib_base;

  assign in_ready_w = live_q && (state_q == COLLECT);
  assign accept     = bus.in_valid && in_ready_w;
  assign nib_base   = BASE_W'(cnt_q) * BASE_W'(NW);

  // XOR of the registered differences only; live input shares never reach
  // this cone, so it cannot recombine shares through glitches.
  always_comb begin
    diff_x = '0;
    for (int s = 0; s < SHARES; s++) begin
      diff_x = diff_x ^ diff_q[s];
    end
  end

  assign fault = diff_valid_q && (|diff_x);

  // One pLayer instance per share keeps the shares physically apart.
  for (genvar s = 0; s < SHARES; s++) begin : g_player
    present_player_share u_player (
      .raw  (raw_q[s]),
      .perm (player_w[s])
    );
  end

  // Next-state logic. A registered mismatch overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && (cnt_q == LAST_NIB)) state_d = CHECK;
      CHECK:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = COLLECT;
      ALARM:   state_d = ALARM;
      default: state_d = COLLECT;
    endcase
    if (fault && (state_q != ALARM)) state_d = ALARM;
  end

  // State register; live_q holds in_ready low until the first edge after
  // reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Beat capture: primary nibble into its slot of each raw share and the
  // per-share primary/redundant difference for the checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      raw_q        <= '0;
      diff_q       <= '0;
      diff_valid_q <= 1'b0;
    end else begin
      diff_valid_q <= accept;
      if (accept) begin
        for (int s = 0; s < SHARES; s++) begin
          raw_q[s][nib_base +: NW] <= bus.sbox_p[s*NW +: NW];
          diff_q[s]                <= bus.sbox_p[s*NW +: NW] ^ bus.sbox_r[s*NW +: NW];
        end
        cnt_q <= cnt_q + 1'b1;
      end else if ((state_q == DONE) && bus.out_ready) begin
        cnt_q <= '0;
      end
    end
  end

  // Output shares are loaded once on entry to DONE and held through
  // backpressure; entering ALARM wipes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_sh_q <= '0;
    end else if (state_d == ALARM) begin
      state_sh_q <= '0;
    end else if ((state_q == CHECK) && (state_d == DONE)) begin
      state_sh_q <= player_w;
    end
  end

  // Sticky alarm, one edge behind the ALARM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_q || (state_q == ALARM);
    end
  end

`ifdef PARTI_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of checked beats that mismatched, including beats still
  // draining after the alarm has fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (fault && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.state_sh  = state_sh_q;
  assign alarm         = alarm_q;

endmodule

// File: tb/tb_parti_present_sbox_collect_chk.sv
// -----------------------------------------------------------------------------
// tb_parti_present_sbox_collect_chk
// Directed bench for the ParTi PRESENT S-box collector/checker: nominal
// collection, share-consistent redundant data with backpressure, position
// mapping, mid-collection reset and faults on beat 5 and beat 15.
// Build option: PARTI_ERR_CNT_EN adds err_cnt checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_parti_present_sbox_collect_chk;

  logic clk;
  logic rst_n;
  logic alarm;
`ifdef PARTI_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int tests;
  int failures;

  // Hand-computed pLayer results.
  localparam logic [63:0] P5   = 64'h0000FFFF0000FFFF;
  localparam logic [63:0] P3   = 64'h00000000FFFFFFFF;
  localparam logic [63:0] PA   = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] PR0  = 64'hFF00F0F0CCCCAAAA;
  localparam logic [63:0] PR1  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] PR2  = 64'h00FF0F0F33335555;
  localparam logic [191:0] NOM  = {PA, P3, P5};
  localparam logic [191:0] RAMP = {PR2, PR1, PR0};

  // Nominal beat (0x5,0x3,0xA), share-consistent and faulty redundant beats.
  localparam logic [11:0] BEAT_NOM = 12'hA35;
  localparam logic [11:0] BEAT_ALT = 12'hA06;
  localparam logic [11:0] BEAT_BAD = 12'hA75;

  parti_present_sbox_collect_chk_if bus ();

  parti_present_sbox_collect_chk dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alarm   (alarm)
`ifdef PARTI_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat, let it cross a rising edge, sample 1 ns later.
  task automatic applyStimulus(input logic [11:0] p, input logic [11:0] r);
    bus.in_valid = 1'b1;
    bus.sbox_p   = p;
    bus.sbox_r   = r;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [191:0] observed,
                             input logic [191:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] rampBeat(input int k);
    logic [3:0] kk;
    kk = k[3:0];
    return {~kk, 4'hF, kk};
  endfunction

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [191:0] sh;
    tests        = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.sbox_p   = '0;
    bus.sbox_r   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_alarm", alarm, 1'b0);
    checkOutput("rst_state_sh", bus.state_sh, '0);
`ifdef PARTI_ERR_CNT_EN
    checkOutput("rst_err_cnt", err_cnt, 8'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);

    // Nominal collection
    for (int k = 0; k < 16; k++) applyStimulus(BEAT_NOM, BEAT_NOM);
    checkOutput("nom_check_in_ready", bus.in_ready, 1'b0);
    checkOutput("nom_check_out_valid", bus.out_valid, 1'b0);
    tick();
    checkOutput("nom_out_valid", bus.out_valid, 1'b1);
    checkOutput("nom_state_sh", bus.state_sh, NOM);
    sh = bus.state_sh;
    checkOutput("nom_share_xor", sh[63:0] ^ sh[127:64] ^ sh[191:128], 64'hFFFFFFFF00000000);
    checkOutput("nom_alarm", alarm, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("nom_after_hs_out_valid", bus.out_valid, 1'b0);
    checkOutput("nom_after_hs_in_ready", bus.in_ready, 1'b1);

    // Share-consistent redundant path, then backpressure in DONE
    for (int k = 0; k < 16; k++) applyStimulus(BEAT_NOM, BEAT_ALT);
    tick();
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_out_valid", bus.out_valid, 1'b1);
      checkOutput("bp_in_ready", bus.in_ready, 1'b0);
      checkOutput("bp_state_sh", bus.state_sh, NOM);
      checkOutput("bp_alarm", alarm, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sbox_p    = rampBeat(0);
    bus.sbox_r    = rampBeat(0);
    tick();
    bus.out_ready = 1'b0;
    checkOutput("bp_hs_in_ready", bus.in_ready, 1'b1);

    // Next collection starts at nibble 0 (position-dependent data)
    for (int k = 0; k < 16; k++) applyStimulus(rampBeat(k), rampBeat(k));
    tick();
    checkOutput("ramp_out_valid", bus.out_valid, 1'b1);
    checkOutput("ramp_state_sh", bus.state_sh, RAMP);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset mid-collection
    for (int k = 0; k < 8; k++) applyStimulus(BEAT_NOM, BEAT_NOM);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_state_sh", bus.state_sh, '0);
    checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_in_ready", bus.in_ready, 1'b1);
    checkOutput("midrst_alarm", alarm, 1'b0);
    for (int k = 0; k < 16; k++) applyStimulus(BEAT_NOM, BEAT_NOM);
    tick();
    checkOutput("midrst_fresh_out_valid", bus.out_valid, 1'b1);
    checkOutput("midrst_fresh_state_sh", bus.state_sh, NOM);

    // Single-bit fault on beat 5 (DONE state still held from above)
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(BEAT_NOM, BEAT_NOM);
    applyStimulus(BEAT_NOM, BEAT_BAD);
    applyStimulus(BEAT_NOM, BEAT_NOM);
    applyStimulus(BEAT_NOM, BEAT_NOM);
    checkOutput("f5_alarm", alarm, 1'b1);
    checkOutput("f5_in_ready", bus.in_ready, 1'b0);
    checkOutput("f5_out_valid", bus.out_valid, 1'b0);
`ifdef PARTI_ERR_CNT_EN
    checkOutput("f5_err_cnt", err_cnt, 8'd1);
`endif
    for (int k = 8; k < 16; k++) applyStimulus(BEAT_NOM, BEAT_NOM);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("f5_hold_out_valid", bus.out_valid, 1'b0);
    end
    bus.out_ready = 1'b0;
    checkOutput("f5_hold_alarm", alarm, 1'b1);
    checkOutput("f5_state_sh", bus.state_sh, '0);

    rst_n = 1'b0;
    #2;
    checkOutput("f5_rst_alarm", alarm, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("f5_rst_in_ready", bus.in_ready, 1'b1);

    // Fault on the last beat: CHECK then ALARM, never DONE
    for (int k = 0; k < 15; k++) applyStimulus(BEAT_NOM, BEAT_NOM);
    applyStimulus(BEAT_NOM, BEAT_BAD);
    checkOutput("f15_check_in_ready", bus.in_ready, 1'b0);
    checkOutput("f15_check_out_valid", bus.out_valid, 1'b0);
    tick();
    checkOutput("f15_e1_out_valid", bus.out_valid, 1'b0);
    tick();
    checkOutput("f15_alarm", alarm, 1'b1);
    checkOutput("f15_state_sh", bus.state_sh, '0);
`ifdef PARTI_ERR_CNT_EN
    checkOutput("f15_err_cnt", err_cnt, 8'd1);
`endif
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("f15_hold_out_valid", bus.out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
